muldiv_sequencer: RTL

Iterative multiply/divide sequencer for the RV32M extension in the pipelined core. It accepts one M-type operation from the Execute stage and runs a shift-add multiply or restoring divide over XLEN cycles. While it runs, it holds the pipeline stalled, then presents the result for exactly one cycle. It sits beside the ALU, is selected by the decoded M-type flag, and feeds the Execute-stage result mux and the hazard/stall logic.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types, opcodes and signedness helpers for the M-extension sequencer
// Contents: muldiv_state_t FSM encoding, funct3 opcode constants, default XLEN,
//           is_signed_a/is_signed_b operand signedness decode.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM (MULHSU keeps it unsigned)
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer with pipeline stall
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, funct3     M-type request from Execute and its op select
//   op_a, op_b        forwarded rs1/rs2 values
//   flush             Execute flush, aborts any operation in progress
//   stall             freeze Fetch/Decode/Execute (combinational from start/flush/state)
//   done, result      registered one-cycle result strobe and result value
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic              sign_a_q;
  logic              sign_b_q;
  logic [XLEN-1:0]   mag_b_q;
  // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Request decode (IDLE only)
  logic            sign_a_d;
  logic            sign_b_d;
  logic [XLEN-1:0] mag_a_d;
  logic [XLEN-1:0] mag_b_d;
  logic            div_zero;
  logic            div_ovf;
  logic            fast_path;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    sign_a_d    = is_signed_a(funct3) & op_a[XLEN-1];
    sign_b_d    = is_signed_b(funct3) & op_b[XLEN-1];
    mag_a_d     = sign_a_d ? (~op_a + 1'b1) : op_a;
    mag_b_d     = sign_b_d ? (~op_b + 1'b1) : op_b;
    div_zero    = funct3[2] && (op_b == '0);
    div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (op_a == MIN_NEG) && (op_b == '1);
    fast_path   = div_zero || div_ovf;
    fast_result = '0;
    if (div_zero) begin
      fast_result = funct3[1] ? op_a : '1;
    end else if (div_ovf) begin
      fast_result = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration of shift-add multiply or restoring divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_d;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mag_b_q};
    mul_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, mag_b_q};
    // Borrow out of the trial subtract means the divisor did not fit: restore
    div_nxt  = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_d    = f3_q[2] ? div_nxt : mul_nxt;
  end

  // Sign fix-up on the final iteration's value, then result select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_result;

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_d + 1'b1) : acc_d;
    quo_fix  = (sign_a_q ^ sign_b_q) ? (~acc_d[XLEN-1:0] + 1'b1) : acc_d[XLEN-1:0];
    rem_fix  = sign_a_q ? (~acc_d[2*XLEN-1:XLEN] + 1'b1) : acc_d[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                        calc_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  calc_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               calc_result = quo_fix;
      F3_REM, F3_REMU:               calc_result = rem_fix;
      default:                       calc_result = '0;
    endcase
  end

  always_comb begin
    case (state_q)
      IDLE:    stall = start & ~flush;
      CALC:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            f3_q     <= funct3;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= {{XLEN{1'b0}}, mag_a_d};
            cnt_q    <= '0;
            if (fast_path) begin
              result_q <= fast_result;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              result_q <= calc_result;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        // DONE is already committed; a flush here only returns to IDLE, as always
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
